mem_bus_arbiter: RTL and testbench

- Shares the single AXI4-Lite memory port between the instruction-fetch unit (read-only) and the load/store unit (read/write).
- Sequences one outstanding transaction at a time. Returns a one-cycle done pulse with data to the owning requester.
- Generates the IFU/LSU stall requests consumed by the pipeline stall/flush controller, and honours that controller's flush.

---
 rtl/mem_bus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single AXI4-Lite port between the IFU (read-only) and the LSU (read/write).
// One transaction in flight; LSU has fixed priority and the IFU result is dropped after a flush.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                ifu_req_i,
  input  logic [ADDR_W-1:0]   ifu_addr_i,
  output logic                ifu_done_o,
  output logic [DATA_W-1:0]   ifu_rdata_o,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wstrb_i,
  output logic                lsu_done_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                bus_err_o,
  output logic                stallreq_ifu_o,
  output logic                stallreq_lsu_o,
  output logic [ADDR_W-1:0]   araddr_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [1:0]          rresp_i,
  input  logic                rvalid_i,
  output logic                rready_o,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  input  logic [1:0]          bresp_i,
  input  logic                bvalid_i,
  output logic                bready_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } owner_t;

  state_t state_r;
  owner_t owner_r;
  logic   drop_pending_r;

  logic rd_done_s, wr_done_s, final_hs_s, resp_err_s;
  logic ifu_drop_s, ifu_owner_s, lsu_owner_s;
  logic aw_ok_s, w_ok_s, ifu_grant_s;

  assign rd_done_s   = rvalid_i & rready_o;
  assign wr_done_s   = bvalid_i & bready_o;
  assign final_hs_s  = rd_done_s | wr_done_s;
  assign resp_err_s  = rd_done_s ? (rresp_i != 2'b00) : (bresp_i != 2'b00);
  assign ifu_owner_s = (owner_r == OWN_IFU);
  assign lsu_owner_s = (owner_r == OWN_LSU);
  // A flush landing on the completion cycle itself also discards the fetch.
  assign ifu_drop_s  = drop_pending_r | flush_i;

  assign ifu_done_o  = final_hs_s & ifu_owner_s & ~ifu_drop_s;
  assign lsu_done_o  = final_hs_s & lsu_owner_s;
  assign bus_err_o   = final_hs_s & resp_err_s & (lsu_owner_s | (ifu_owner_s & ~ifu_drop_s));
  assign ifu_rdata_o = rdata_i;
  assign lsu_rdata_o = rdata_i;

  assign stallreq_ifu_o = rst_n & ifu_req_i & ~ifu_done_o;
  assign stallreq_lsu_o = rst_n & lsu_req_i & ~lsu_done_o;

  assign aw_ok_s     = ~awvalid_o | awready_i;
  assign w_ok_s      = ~wvalid_o | wready_i;
  assign ifu_grant_s = ifu_req_i & ~flush_i;

  // Transaction sequencer: grant in IDLE, then drive the AXI channels with registered valids/readies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      owner_r        <= OWN_NONE;
      drop_pending_r <= 1'b0;
      araddr_o       <= {ADDR_W{1'b0}};
      arvalid_o      <= 1'b0;
      rready_o       <= 1'b0;
      awaddr_o       <= {ADDR_W{1'b0}};
      awvalid_o      <= 1'b0;
      wdata_o        <= {DATA_W{1'b0}};
      wstrb_o        <= {(DATA_W/8){1'b0}};
      wvalid_o       <= 1'b0;
      bready_o       <= 1'b0;
    end else begin
      if (flush_i && owner_r == OWN_IFU) begin
        drop_pending_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (lsu_req_i) begin
            owner_r <= OWN_LSU;
            if (lsu_we_i) begin
              state_r   <= WR;
              awaddr_o  <= lsu_addr_i;
              wdata_o   <= lsu_wdata_i;
              wstrb_o   <= lsu_wstrb_i;
              awvalid_o <= 1'b1;
              wvalid_o  <= 1'b1;
            end else begin
              state_r   <= RD_ADDR;
              araddr_o  <= lsu_addr_i;
              arvalid_o <= 1'b1;
            end
          end else if (ifu_grant_s) begin
            owner_r   <= OWN_IFU;
            state_r   <= RD_ADDR;
            araddr_o  <= ifu_addr_i;
            arvalid_o <= 1'b1;
          end else begin
            owner_r <= OWN_NONE;
          end
        end
        RD_ADDR: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            state_r   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid_i) begin
            rready_o       <= 1'b0;
            state_r        <= IDLE;
            owner_r        <= OWN_NONE;
            drop_pending_r <= 1'b0;
          end
        end
        WR: begin
          if (aw_ok_s && w_ok_s) begin
            awvalid_o <= 1'b0;
            wvalid_o  <= 1'b0;
            bready_o  <= 1'b1;
            state_r   <= WR_RESP;
          end else begin
            if (awready_i) begin
              awvalid_o <= 1'b0;
            end
            if (wready_i) begin
              wvalid_o <= 1'b0;
            end
          end
        end
        WR_RESP: begin
          if (bvalid_i) begin
            bready_o       <= 1'b0;
            state_r        <= IDLE;
            owner_r        <= OWN_NONE;
            drop_pending_r <= 1'b0;
          end
        end
        default: begin
          state_r        <= IDLE;
          owner_r        <= OWN_NONE;
          drop_pending_r <= 1'b0;
          arvalid_o      <= 1'b0;
          rready_o       <= 1'b0;
          awvalid_o      <= 1'b0;
          wvalid_o       <= 1'b0;
          bready_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; the bench plays the AXI-Lite slave cycle by cycle.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        ifu_req_i = 1'b0;
  logic [31:0] ifu_addr_i = 32'h0;
  logic        ifu_done_o;
  logic [31:0] ifu_rdata_o;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [31:0] lsu_addr_i = 32'h0;
  logic [31:0] lsu_wdata_i = 32'h0;
  logic [3:0]  lsu_wstrb_i = 4'h0;
  logic        lsu_done_o;
  logic [31:0] lsu_rdata_o;
  logic        bus_err_o, stallreq_ifu_o, stallreq_lsu_o;
  logic [31:0] araddr_o;
  logic        arvalid_o;
  logic        arready_i = 1'b0;
  logic [31:0] rdata_i = 32'h0;
  logic [1:0]  rresp_i = 2'b00;
  logic        rvalid_i = 1'b0;
  logic        rready_o;
  logic [31:0] awaddr_o;
  logic        awvalid_o;
  logic        awready_i = 1'b0;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wvalid_o;
  logic        wready_i = 1'b0;
  logic [1:0]  bresp_i = 2'b00;
  logic        bvalid_i = 1'b0;
  logic        bready_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_done_o(ifu_done_o), .ifu_rdata_o(ifu_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_wstrb_i(lsu_wstrb_i), .lsu_done_o(lsu_done_o), .lsu_rdata_o(lsu_rdata_o),
    .bus_err_o(bus_err_o), .stallreq_ifu_o(stallreq_ifu_o), .stallreq_lsu_o(stallreq_lsu_o),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
  );

  // Advance to just after the next rising edge; inputs set afterwards belong to the new cycle.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++; if (arvalid_o !== 1'b0) begin errors++; $display("FAIL reset_arvalid got=%0h exp=0", arvalid_o); end
    checks++; if ({awvalid_o, wvalid_o, rready_o, bready_o} !== 4'b0000) begin errors++; $display("FAIL reset_valids got=%b exp=0000", {awvalid_o, wvalid_o, rready_o, bready_o}); end
    checks++; if ({ifu_done_o, lsu_done_o, bus_err_o} !== 3'b000) begin errors++; $display("FAIL reset_done got=%b exp=000", {ifu_done_o, lsu_done_o, bus_err_o}); end
    checks++; if ({araddr_o, awaddr_o, wdata_o} !== 96'h0) begin errors++; $display("FAIL reset_addr_data got=%h exp=0", {araddr_o, awaddr_o, wdata_o}); end
    checks++; if (wstrb_o !== 4'h0) begin errors++; $display("FAIL reset_wstrb got=%h exp=0", wstrb_o); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ifu_read;
    ifu_req_i = 1'b1; ifu_addr_i = 32'h8000_0000;
    #1;
    checks++; if (stallreq_ifu_o !== 1'b1) begin errors++; $display("FAIL ifu_stall_n got=%0h exp=1", stallreq_ifu_o); end
    checks++; if (arvalid_o !== 1'b0) begin errors++; $display("FAIL ifu_arvalid_n got=%0h exp=0", arvalid_o); end
    tick();
    arready_i = 1'b1;
    #1;
    checks++; if (arvalid_o !== 1'b1) begin errors++; $display("FAIL ifu_arvalid_n1 got=%0h exp=1", arvalid_o); end
    checks++; if (araddr_o !== 32'h8000_0000) begin errors++; $display("FAIL ifu_araddr got=%h exp=80000000", araddr_o); end
    checks++; if (stallreq_ifu_o !== 1'b1) begin errors++; $display("FAIL ifu_stall_n1 got=%0h exp=1", stallreq_ifu_o); end
    tick();
    arready_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h0000_0413; rresp_i = 2'b00;
    #1;
    checks++; if (arvalid_o !== 1'b0) begin errors++; $display("FAIL ifu_arvalid_n2 got=%0h exp=0", arvalid_o); end
    checks++; if (ifu_done_o !== 1'b1) begin errors++; $display("FAIL ifu_done got=%0h exp=1", ifu_done_o); end
    checks++; if (ifu_rdata_o !== 32'h0000_0413) begin errors++; $display("FAIL ifu_rdata got=%h exp=00000413", ifu_rdata_o); end
    checks++; if (stallreq_ifu_o !== 1'b0) begin errors++; $display("FAIL ifu_stall_n2 got=%0h exp=0", stallreq_ifu_o); end
    checks++; if ({lsu_done_o, bus_err_o} !== 2'b00) begin errors++; $display("FAIL ifu_no_lsu_err got=%b exp=00", {lsu_done_o, bus_err_o}); end
    tick();
    ifu_req_i = 1'b0; rvalid_i = 1'b0;
    #1;
    checks++; if ({rready_o, arvalid_o, ifu_done_o} !== 3'b000) begin errors++; $display("FAIL ifu_idle_after got=%b exp=000", {rready_o, arvalid_o, ifu_done_o}); end
    tick();
  endtask

  task automatic test_priority;
    ifu_req_i = 1'b1; ifu_addr_i = 32'h8000_0004;
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h8000_1000;
    lsu_wdata_i = 32'hDEAD_BEEF; lsu_wstrb_i = 4'hF;
    tick();
    lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0; lsu_wstrb_i = 4'h0;
    awready_i = 1'b1; wready_i = 1'b1;
    #1;
    checks++; if ({awvalid_o, wvalid_o, arvalid_o} !== 3'b110) begin errors++; $display("FAIL prio_valids got=%b exp=110", {awvalid_o, wvalid_o, arvalid_o}); end
    checks++; if (awaddr_o !== 32'h8000_1000) begin errors++; $display("FAIL prio_awaddr got=%h exp=80001000", awaddr_o); end
    checks++; if (wdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL prio_wdata got=%h exp=deadbeef", wdata_o); end
    checks++; if (wstrb_o !== 4'hF) begin errors++; $display("FAIL prio_wstrb got=%h exp=f", wstrb_o); end
    checks++; if ({stallreq_ifu_o, stallreq_lsu_o} !== 2'b11) begin errors++; $display("FAIL prio_stalls got=%b exp=11", {stallreq_ifu_o, stallreq_lsu_o}); end
    tick();
    awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b1; bresp_i = 2'b00;
    #1;
    checks++; if ({awvalid_o, wvalid_o, bready_o} !== 3'b001) begin errors++; $display("FAIL prio_wresp got=%b exp=001", {awvalid_o, wvalid_o, bready_o}); end
    checks++; if ({lsu_done_o, ifu_done_o, bus_err_o} !== 3'b100) begin errors++; $display("FAIL prio_lsu_done got=%b exp=100", {lsu_done_o, ifu_done_o, bus_err_o}); end
    tick();
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; bvalid_i = 1'b0;
    #1;
    checks++; if ({arvalid_o, bready_o, stallreq_ifu_o} !== 3'b001) begin errors++; $display("FAIL prio_idle_cycle got=%b exp=001", {arvalid_o, bready_o, stallreq_ifu_o}); end
    tick();
    arready_i = 1'b1;
    #1;
    checks++; if (arvalid_o !== 1'b1) begin errors++; $display("FAIL prio_ifu_arvalid got=%0h exp=1", arvalid_o); end
    checks++; if (araddr_o !== 32'h8000_0004) begin errors++; $display("FAIL prio_ifu_araddr got=%h exp=80000004", araddr_o); end
    tick();
    arready_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h0000_0013;
    #1;
    checks++; if (ifu_done_o !== 1'b1) begin errors++; $display("FAIL prio_ifu_done got=%0h exp=1", ifu_done_o); end
    tick();
    ifu_req_i = 1'b0; rvalid_i = 1'b0;
    tick();
  endtask

  task automatic test_split_write;
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h0000_0010;
    lsu_wdata_i = 32'h1122_3344; lsu_wstrb_i = 4'b0011;
    tick();
    wready_i = 1'b1;
    #1;
    checks++; if ({awvalid_o, wvalid_o} !== 2'b11) begin errors++; $display("FAIL split_start got=%b exp=11", {awvalid_o, wvalid_o}); end
    tick();
    wready_i = 1'b0;
    #1;
    checks++; if ({awvalid_o, wvalid_o} !== 2'b10) begin errors++; $display("FAIL split_w_dropped got=%b exp=10", {awvalid_o, wvalid_o}); end
    checks++; if (bready_o !== 1'b0) begin errors++; $display("FAIL split_bready_early got=%0h exp=0", bready_o); end
    tick();
    awready_i = 1'b1; bvalid_i = 1'b1;
    #1;
    checks++; if ({awvalid_o, wvalid_o, bready_o} !== 3'b100) begin errors++; $display("FAIL split_aw_hold got=%b exp=100", {awvalid_o, wvalid_o, bready_o}); end
    checks++; if (lsu_done_o !== 1'b0) begin errors++; $display("FAIL split_done_early got=%0h exp=0", lsu_done_o); end
    tick();
    awready_i = 1'b0;
    #1;
    checks++; if ({awvalid_o, bready_o} !== 2'b01) begin errors++; $display("FAIL split_resp got=%b exp=01", {awvalid_o, bready_o}); end
    checks++; if (lsu_done_o !== 1'b1) begin errors++; $display("FAIL split_done got=%0h exp=1", lsu_done_o); end
    tick();
    lsu_req_i = 1'b0; lsu_we_i = 1'b0;
    #1;
    checks++; if ({bready_o, lsu_done_o} !== 2'b00) begin errors++; $display("FAIL split_single_b got=%b exp=00", {bready_o, lsu_done_o}); end
    bvalid_i = 1'b0;
    tick();
  endtask

  task automatic test_flush;
    ifu_req_i = 1'b1; ifu_addr_i = 32'h0000_0100;
    tick();
    flush_i = 1'b1; arready_i = 1'b1;
    #1;
    checks++; if (arvalid_o !== 1'b1) begin errors++; $display("FAIL flush_arvalid got=%0h exp=1", arvalid_o); end
    tick();
    flush_i = 1'b0; arready_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h0000_1234; rresp_i = 2'b10;
    #1;
    checks++; if (rready_o !== 1'b1) begin errors++; $display("FAIL flush_rready got=%0h exp=1", rready_o); end
    checks++; if ({ifu_done_o, bus_err_o} !== 2'b00) begin errors++; $display("FAIL flush_suppress got=%b exp=00", {ifu_done_o, bus_err_o}); end
    tick();
    rvalid_i = 1'b0; rresp_i = 2'b00; ifu_addr_i = 32'h0000_0200;
    #1;
    checks++; if ({rready_o, arvalid_o} !== 2'b00) begin errors++; $display("FAIL flush_idle got=%b exp=00", {rready_o, arvalid_o}); end
    tick();
    arready_i = 1'b1;
    #1;
    checks++; if (araddr_o !== 32'h0000_0200) begin errors++; $display("FAIL flush_next_addr got=%h exp=00000200", araddr_o); end
    tick();
    arready_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h0000_5678;
    #1;
    checks++; if ({ifu_done_o, bus_err_o} !== 2'b10) begin errors++; $display("FAIL flush_next_done got=%b exp=10", {ifu_done_o, bus_err_o}); end
    checks++; if (ifu_rdata_o !== 32'h0000_5678) begin errors++; $display("FAIL flush_next_rdata got=%h exp=00005678", ifu_rdata_o); end
    tick();
    ifu_req_i = 1'b0; rvalid_i = 1'b0;
    tick();
  endtask

  task automatic test_read_error;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h0000_2000;
    tick();
    arready_i = 1'b1;
    #1;
    checks++; if ({arvalid_o, awvalid_o} !== 2'b10) begin errors++; $display("FAIL err_arvalid got=%b exp=10", {arvalid_o, awvalid_o}); end
    checks++; if (araddr_o !== 32'h0000_2000) begin errors++; $display("FAIL err_araddr got=%h exp=00002000", araddr_o); end
    tick();
    arready_i = 1'b0; rvalid_i = 1'b1; rresp_i = 2'b10; rdata_i = 32'h0000_CAFE;
    #1;
    checks++; if ({lsu_done_o, bus_err_o, ifu_done_o} !== 3'b110) begin errors++; $display("FAIL err_pulse got=%b exp=110", {lsu_done_o, bus_err_o, ifu_done_o}); end
    checks++; if (lsu_rdata_o !== 32'h0000_CAFE) begin errors++; $display("FAIL err_rdata got=%h exp=0000cafe", lsu_rdata_o); end
    tick();
    lsu_req_i = 1'b0; rvalid_i = 1'b0; rresp_i = 2'b00;
    #1;
    checks++; if ({lsu_done_o, bus_err_o} !== 2'b00) begin errors++; $display("FAIL err_after got=%b exp=00", {lsu_done_o, bus_err_o}); end
    tick();
  endtask

  task automatic test_reset_mid;
    ifu_req_i = 1'b1; ifu_addr_i = 32'h0000_0300;
    tick();
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0;
    #1;
    checks++; if (rready_o !== 1'b1) begin errors++; $display("FAIL rstmid_in_rd_data got=%0h exp=1", rready_o); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o} !== 5'b00000) begin errors++; $display("FAIL rstmid_valids got=%b exp=00000", {arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o}); end
    checks++; if ({ifu_done_o, lsu_done_o, bus_err_o, stallreq_ifu_o, stallreq_lsu_o} !== 5'b00000) begin errors++; $display("FAIL rstmid_flags got=%b exp=00000", {ifu_done_o, lsu_done_o, bus_err_o, stallreq_ifu_o, stallreq_lsu_o}); end
    checks++; if (araddr_o !== 32'h0) begin errors++; $display("FAIL rstmid_araddr got=%h exp=0", araddr_o); end
    tick();
    ifu_req_i = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if ({arvalid_o, rready_o} !== 2'b00) begin errors++; $display("FAIL rstmid_release got=%b exp=00", {arvalid_o, rready_o}); end
    tick();
    ifu_req_i = 1'b1; ifu_addr_i = 32'h0000_0400;
    tick();
    arready_i = 1'b1;
    #1;
    checks++; if ({arvalid_o, araddr_o} !== {1'b1, 32'h0000_0400}) begin errors++; $display("FAIL rstmid_fresh_ar got=%h exp=100000400", {arvalid_o, araddr_o}); end
    tick();
    arready_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h0000_9ABC;
    #1;
    checks++; if ({ifu_done_o, ifu_rdata_o} !== {1'b1, 32'h0000_9ABC}) begin errors++; $display("FAIL rstmid_fresh_done got=%h exp=100009abc", {ifu_done_o, ifu_rdata_o}); end
    tick();
    ifu_req_i = 1'b0; rvalid_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_priority();
    test_split_write();
    test_flush();
    test_read_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
